// File: rtl/zelda_pkg.sv
// Shared definitions for the player-character blocks: playfield geometry,
// action/direction codes and the collision-map addressing helper.
package zelda_pkg;

  localparam int SCREEN_W   = 320;
  localparam int SCREEN_H   = 240;
  localparam int SPRITE     = 16;
  localparam int CELL_SHIFT = 2;
  localparam int MAP_COLS   = SCREEN_W >> CELL_SHIFT;

  localparam logic [9:0] SCREEN_W10 = 10'(SCREEN_W);
  localparam logic [9:0] SCREEN_H10 = 10'(SCREEN_H);
  localparam logic [9:0] SPRITE10   = 10'(SPRITE);

  typedef enum logic [2:0] {
    NO_ACTION = 3'd0,
    ATTACK    = 3'd1,
    UP        = 3'd2,
    DOWN      = 3'd3,
    LEFT      = 3'd4,
    RIGHT     = 3'd5
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_FINISH
  } scan_state_e;

  // cell_y*80 + cell_x built from two shifts so no multiplier is inferred
  function automatic logic [12:0] cell_addr(input logic [9:0] px, input logic [9:0] py);
    logic [12:0] cx;
    logic [12:0] cy;
    cx = 13'(px >> CELL_SHIFT);
    cy = 13'(py >> CELL_SHIFT);
    return (cy << 6) + (cy << 4) + cx;
  endfunction

endpackage

// File: rtl/box_overlap16.sv
// Combinational overlap test between two 16x16 boxes given by their
// top-left corners; touching edges do not count as overlap.
module box_overlap16 (
  input  logic [8:0] ax,
  input  logic [7:0] ay,
  input  logic [8:0] bx,
  input  logic [7:0] by,
  input  logic       en,
  output logic       hit
);

  logic signed [9:0] dx;
  logic signed [9:0] dy;

  assign dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign dy = $signed({2'b0, ay}) - $signed({2'b0, by});

  assign hit = en
             && (dx > -10'sd16) && (dx < 10'sd16)
             && (dy > -10'sd16) && (dy < 10'sd16);

endmodule

// File: rtl/link_collision_detector.sv
// Evaluates a requested character move: scans the 16 leading-edge pixels
// against the collision-map ROM and tests overlap with three enemy boxes.
module link_collision_detector
  import zelda_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  x_pos,
  input  logic [7:0]  y_pos,
  input  logic [2:0]  direction,
  input  logic [26:0] enemy_x,
  input  logic [23:0] enemy_y,
  input  logic [2:0]  enemy_alive,
  output logic [12:0] map_addr,
  input  logic        map_q,
  output logic [3:0]  collision,
  output logic        busy,
  output logic        done
);

  scan_state_e state, state_nx;

  logic [8:0]  lx;
  logic [7:0]  ly;
  logic [2:0]  ldir;
  logic [26:0] lex;
  logic [23:0] ley;
  logic [2:0]  lalive;
  logic [3:0]  idx;
  logic        scan_mode;
  logic        edge_blk;
  logic        rd_pend;
  logic        terrain_acc;

  logic        req_scan;
  logic        req_blk;
  logic [9:0]  in_x10;
  logic [9:0]  in_y10;
  logic [9:0]  x10;
  logic [9:0]  y10;
  logic [9:0]  i10;
  logic [9:0]  px;
  logic [9:0]  py;
  logic [2:0]  hit;

  // Moves whose leading edge would leave the playfield are blocked outright,
  // which also keeps every scanned coordinate inside the map.
  always_comb begin
    in_x10   = {1'b0, x_pos};
    in_y10   = {2'b0, y_pos};
    req_scan = 1'b0;
    req_blk  = 1'b0;
    case (direction)
      UP: begin
        if (in_y10 == '0 || in_x10 + SPRITE10 > SCREEN_W10) req_blk = 1'b1;
        else                                                req_scan = 1'b1;
      end
      DOWN: begin
        if (in_y10 + SPRITE10 >= SCREEN_H10 || in_x10 + SPRITE10 > SCREEN_W10) req_blk = 1'b1;
        else                                                                   req_scan = 1'b1;
      end
      LEFT: begin
        if (in_x10 == '0 || in_y10 + SPRITE10 > SCREEN_H10) req_blk = 1'b1;
        else                                                req_scan = 1'b1;
      end
      RIGHT: begin
        if (in_x10 + SPRITE10 >= SCREEN_W10 || in_y10 + SPRITE10 > SCREEN_H10) req_blk = 1'b1;
        else                                                                   req_scan = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    x10 = {1'b0, lx};
    y10 = {2'b0, ly};
    i10 = {6'b0, idx};
    px  = x10;
    py  = y10;
    case (ldir)
      UP: begin
        px = x10 + i10;
        py = y10 - 10'd1;
      end
      DOWN: begin
        px = x10 + i10;
        py = y10 + SPRITE10;
      end
      LEFT: begin
        px = x10 - 10'd1;
        py = y10 + i10;
      end
      RIGHT: begin
        px = x10 + SPRITE10;
        py = y10 + i10;
      end
      default: ;
    endcase
  end

  assign map_addr = (state == S_SCAN) ? cell_addr(px, py) : '0;

  for (genvar k = 0; k < 3; k++) begin : g_enemy
    box_overlap16 u_overlap (
      .ax (lx),
      .ay (ly),
      .bx (lex[9*k +: 9]),
      .by (ley[8*k +: 8]),
      .en (lalive[k]),
      .hit(hit[k])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Unscanned requests pass through DRAIN so the result lands on the same
  // registered path and done still appears two cycles after start.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = req_scan ? S_SCAN : S_DRAIN;
      end
      S_SCAN: begin
        busy = 1'b1;
        if (idx == 4'd15) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy     = 1'b1;
        state_nx = S_FINISH;
      end
      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lx          <= '0;
      ly          <= '0;
      ldir        <= '0;
      lex         <= '0;
      ley         <= '0;
      lalive      <= '0;
      idx         <= '0;
      scan_mode   <= 1'b0;
      edge_blk    <= 1'b0;
      rd_pend     <= 1'b0;
      terrain_acc <= 1'b0;
      collision   <= '0;
    end else begin
      // ROM data trails the address by one cycle
      rd_pend <= (state == S_SCAN);
      if (rd_pend) terrain_acc <= terrain_acc | map_q;
      case (state)
        S_IDLE: begin
          if (start) begin
            lx          <= x_pos;
            ly          <= y_pos;
            ldir        <= direction;
            lex         <= enemy_x;
            ley         <= enemy_y;
            lalive      <= enemy_alive;
            idx         <= '0;
            scan_mode   <= req_scan;
            edge_blk    <= req_blk;
            terrain_acc <= 1'b0;
          end
        end
        S_SCAN:  idx <= idx + 4'd1;
        S_DRAIN: collision <= {hit, scan_mode ? (terrain_acc | map_q) : edge_blk};
        default: ;
      endcase
    end
  end

endmodule
